// File: rtl/cnt_chk_pkg.sv
// cnt_chk_pkg: shared FSM encoding, default parameters and log entry layout for counter_checker
package cnt_chk_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, ACQ = 2'd2, LOCKED = 2'd3} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_LOCK_CNT = 3;
  localparam int DEF_WRAP_W = 8;
  localparam int DEF_ERR_W = 8;
  localparam int DEF_LOG_DEPTH = 4;
  localparam int LOG_BAD_LSB = 0;
  function automatic int log_exp_lsb(input int width);
    return width;
  endfunction
endpackage

// File: rtl/cnt_chk_log_fifo.sv
// cnt_chk_log_fifo: sync FIFO holding error log entries; push when full succeeds only with a pop
module cnt_chk_log_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd];
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge CLK)
    if (do_push && !RST && !flush) mem[wr] <= din;
endmodule

// File: rtl/counter_checker.sv
// counter_checker: locks onto an increment-by-one count, reports wraps and continuity errors;
// defining CNT_CHK_LOG_EN adds an error log FIFO
module counter_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int WRAP_W = DEF_WRAP_W,
  parameter int ERR_W = DEF_ERR_W,
  parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   counter_in,
  input  logic               enable,
  input  logic               clear,
  output logic               locked,
  output logic               wrap_pulse,
  output logic [WRAP_W-1:0]  wrap_count,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic               err_sticky,
  output logic [WIDTH-1:0]   exp_value,
  output logic [WIDTH-1:0]   bad_value,
  output logic               log_valid,
  output logic [2*WIDTH-1:0] log_data,
  input  logic               log_pop
);
  localparam int MCW = $clog2(LOCK_CNT + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] prev, prev_n, inc;
  logic [MCW-1:0] match_cnt, match_cnt_n, match_inc;
  logic hit, err, wrap;
  always_comb begin
    inc = prev + 1'b1;
    match_inc = match_cnt + 1'b1;
    hit = counter_in == inc;
    err = enable && state == LOCKED && !hit;
    wrap = enable && state == LOCKED && hit && &prev;
    state_n = state;
    prev_n = prev;
    match_cnt_n = match_cnt;
    if (!enable) state_n = IDLE;
    else
      unique case (state)
        IDLE: state_n = SYNC;
        SYNC: begin
          prev_n = counter_in;
          match_cnt_n = '0;
          state_n = ACQ;
        end
        ACQ: begin
          prev_n = counter_in;
          match_cnt_n = hit ? match_inc : '0;
          state_n = hit && match_inc == MCW'(LOCK_CNT) ? LOCKED : ACQ;
        end
        LOCKED: begin
          prev_n = counter_in;
          match_cnt_n = hit ? match_cnt : '0;
          state_n = hit ? LOCKED : ACQ;
        end
      endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      prev <= '0;
      match_cnt <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      err_sticky <= 1'b0;
      exp_value <= '0;
      bad_value <= '0;
    end else begin
      state <= state_n;
      prev <= prev_n;
      match_cnt <= match_cnt_n;
      wrap_pulse <= wrap && !clear;
      err_pulse <= err && !clear;
      wrap_count <= clear ? '0 : wrap_count + WRAP_W'(wrap);
      err_count <= clear ? '0 : err_count + ERR_W'(err && !(&err_count));
      err_sticky <= !clear && (err_sticky || err);
      if (err && !clear) begin
        exp_value <= inc;
        bad_value <= counter_in;
      end
    end
  end
  assign locked = state == LOCKED;
`ifdef CNT_CHK_LOG_EN
  logic log_empty, log_full_unused;
  cnt_chk_log_fifo #(.W(2*WIDTH), .DEPTH(LOG_DEPTH)) u_log (
    .CLK(CLK),
    .RST(RST),
    .flush(clear),
    .push(err && !clear),
    .pop(log_pop),
    .din({inc, counter_in}),
    .dout(log_data),
    .full(log_full_unused),
    .empty(log_empty)
  );
  assign log_valid = !log_empty;
`else
  localparam int LOG_DEPTH_UNUSED = LOG_DEPTH;
  logic log_pop_unused;
  assign log_pop_unused = log_pop;
  assign log_valid = 1'b0;
  assign log_data = '0;
`endif
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: scoreboard bench for counter_checker, reference model predicts every cycle
module tb_counter_checker;
  logic CLK = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0, pop = 1'b0;
  logic [3:0] cin = 4'd0;
  logic locked, wrap_pulse, err_pulse, err_sticky, log_valid;
  logic [7:0] wrap_count, err_count, log_data;
  logic [3:0] exp_value, bad_value;
  int checks = 0, fails = 0, cyc = 0;
  int ms = 0, mprev = 0, mmc = 0, mwp = 0, mwc = 0, mep = 0, mec = 0, mst = 0, mexp = 0, mbad = 0;
  int mlog[$];
  logic [36:0] sb[$];

  counter_checker dut (
    .CLK(CLK), .RST(rst), .counter_in(cin), .enable(en), .clear(clr),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .err_pulse(err_pulse), .err_count(err_count), .err_sticky(err_sticky),
    .exp_value(exp_value), .bad_value(bad_value),
    .log_valid(log_valid), .log_data(log_data), .log_pop(pop)
  );

  always #5 CLK = ~CLK;

  task automatic model_step();
    int want;
    bit hit, e, w;
    if (rst) begin
      ms = 0; mprev = 0; mmc = 0; mwp = 0; mwc = 0; mep = 0; mec = 0; mst = 0; mexp = 0; mbad = 0;
      mlog.delete();
      return;
    end
    want = (mprev + 1) % 16;
    hit = (int'(cin) == want);
    e = en && ms == 3 && !hit;
    w = en && ms == 3 && hit && mprev == 15;
    mep = int'(e && !clr);
    mwp = int'(w && !clr);
    if (clr) begin
      mwc = 0; mec = 0; mst = 0;
      mlog.delete();
    end else begin
      if (w) mwc = (mwc + 1) % 256;
      if (e) begin
        if (mec < 255) mec++;
        mst = 1; mexp = want; mbad = int'(cin);
      end
`ifdef CNT_CHK_LOG_EN
      if (pop && mlog.size() > 0) void'(mlog.pop_front());
      if (e && mlog.size() < 4) mlog.push_back(want * 16 + int'(cin));
`endif
    end
    if (!en) ms = 0;
    else if (ms == 0) ms = 1;
    else if (ms == 1) begin mprev = int'(cin); mmc = 0; ms = 2; end
    else if (ms == 2) begin
      if (hit) begin mmc++; if (mmc == 3) ms = 3; end
      else mmc = 0;
      mprev = int'(cin);
    end else begin
      if (!hit) begin ms = 2; mmc = 0; end
      mprev = int'(cin);
    end
  endtask

  task automatic tick();
    logic [36:0] want, got;
    logic lv;
    logic [7:0] ld;
    model_step();
    lv = mlog.size() > 0;
    ld = lv ? 8'(mlog[0]) : 8'd0;
    sb.push_back({ms == 3, 1'(mwp), 8'(mwc), 1'(mep), 8'(mec), 1'(mst), 4'(mexp), 4'(mbad), lv, ld});
    @(posedge CLK);
    #1;
    cyc++;
    got = {locked, wrap_pulse, wrap_count, err_pulse, err_count, err_sticky, exp_value, bad_value, log_valid, log_data};
    want = sb.pop_front();
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL scoreboard cycle %0d got %h want %h", cyc, got, want);
    end
  endtask

  task automatic relock();
    int n = 0;
    while (locked !== 1'b1 && n < 20) begin tick(); cin++; n++; end
    checks++;
    if (locked !== 1'b1) begin fails++; $display("FAIL relock timeout locked=%b", locked); end
  endtask

  task automatic skip_err(output logic [7:0] pair);
    pair = {cin, cin + 4'd1};
    cin++;
    tick();
    cin++;
    checks++;
    if (err_pulse !== 1'b1) begin fails++; $display("FAIL skip_err_pulse got %b want 1", err_pulse); end
  endtask

  task automatic do_clear();
    clr = 1'b1; tick(); cin++; clr = 1'b0;
    checks++;
    if (err_count !== 8'd0 || err_sticky !== 1'b0 || wrap_count !== 8'd0 || log_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear got cnt=%0d sticky=%b wraps=%0d lv=%b want 0", err_count, err_sticky, wrap_count, log_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick();
    checks++;
    if ({locked, wrap_pulse, err_pulse, err_sticky, log_valid} !== 5'd0 || err_count !== 8'd0 || wrap_count !== 8'd0 || exp_value !== 4'd0 || bad_value !== 4'd0 || log_data !== 8'd0) begin
      fails++;
      $display("FAIL reset_outputs got locked=%b cnt=%0d wraps=%0d want all 0", locked, err_count, wrap_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_lock_and_wrap();
    int n = 0, w = 0, first = -1, second = -1;
    en = 1'b1; cin = 4'd0;
    while (locked !== 1'b1 && n < 20) begin tick(); cin++; n++; end
    checks++;
    if (n != 5) begin fails++; $display("FAIL lock_latency got %0d cycles want 5", n); end
    for (int i = 0; i < 40 && w < 2; i++) begin
      tick(); cin++;
      if (wrap_pulse === 1'b1) begin
        if (w == 0) first = i; else second = i;
        w++;
      end
    end
    checks++;
    if (w != 2 || second - first != 16) begin fails++; $display("FAIL wrap_spacing got %0d pulses gap %0d want 2 gap 16", w, second - first); end
    checks++;
    if (wrap_count !== 8'd2) begin fails++; $display("FAIL wrap_count got %0d want 2", wrap_count); end
  endtask

  task automatic test_skip();
    int n = 0;
    while (cin != 4'd6 && n < 20) begin tick(); cin++; n++; end
    cin = 4'd7; tick();
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || exp_value !== 4'd6 || bad_value !== 4'd7 || locked !== 1'b0 || err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL skip got pulse=%b cnt=%0d exp=%0d bad=%0d locked=%b want 1 1 6 7 0", err_pulse, err_count, exp_value, bad_value, locked);
    end
    cin = 4'd8; tick(); tick_inc_pair();
    checks++;
    if (err_pulse !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL skip_pulse_width got pulse=%b locked=%b want 0 0", err_pulse, locked); end
    tick();
    checks++;
    if (locked !== 1'b1) begin fails++; $display("FAIL skip_relock got %b want 1", locked); end
    cin++;
  endtask

  task automatic tick_inc_pair();
    cin++; tick(); cin++;
  endtask

  task automatic test_stall();
    int n = 0;
    bit any_lock = 0;
    do_clear();
    relock();
    while (cin != 4'd9 && n < 20) begin tick(); cin++; n++; end
    tick();
    for (int i = 0; i < 9; i++) begin tick(); if (locked !== 1'b0) any_lock = 1; end
    checks++;
    if (err_count !== 8'd1) begin fails++; $display("FAIL stall_err_count got %0d want 1", err_count); end
    checks++;
    if (any_lock) begin fails++; $display("FAIL stall_locked got 1 want 0"); end
    cin = 4'd10; tick(); cin = 4'd11; tick();
    checks++;
    if (locked !== 1'b0) begin fails++; $display("FAIL stall_early_lock got %b want 0", locked); end
    cin = 4'd12; tick();
    checks++;
    if (locked !== 1'b1) begin fails++; $display("FAIL stall_relock got %b want 1", locked); end
    cin++;
  endtask

  task automatic test_clear_skip();
    relock();
    clr = 1'b1; cin++; tick(); clr = 1'b0; cin++;
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd0 || err_sticky !== 1'b0 || locked !== 1'b0) begin
      fails++;
      $display("FAIL clear_skip got pulse=%b cnt=%0d sticky=%b locked=%b want 0 0 0 0", err_pulse, err_count, err_sticky, locked);
    end
    relock();
  endtask

  task automatic test_log();
    logic [7:0] pairs[5];
    int n = 0;
    do_clear();
    relock();
    while (cin != 4'd6 && n < 20) begin tick(); cin++; n++; end
    skip_err(pairs[0]);
    for (int i = 1; i < 5; i++) begin relock(); skip_err(pairs[i]); end
    relock();
`ifdef CNT_CHK_LOG_EN
    checks++;
    if (pairs[0] !== 8'h67) begin fails++; $display("FAIL log_first_pair got %h want 67", pairs[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_valid !== 1'b1 || log_data !== pairs[i]) begin
        fails++;
        $display("FAIL log_entry%0d got valid=%b data=%h want 1 %h", i, log_valid, log_data, pairs[i]);
      end
      pop = 1'b1; tick(); pop = 1'b0; cin++;
    end
    checks++;
    if (log_valid !== 1'b0) begin fails++; $display("FAIL log_drop got valid=%b want 0", log_valid); end
`else
    pop = 1'b1; tick(); pop = 1'b0; cin++;
    checks++;
    if (log_valid !== 1'b0 || log_data !== 8'd0) begin fails++; $display("FAIL log_disabled got %b %h want 0 00", log_valid, log_data); end
`endif
  endtask

  task automatic test_saturate();
    logic [7:0] pr;
    do_clear();
    for (int i = 0; i < 257; i++) begin relock(); skip_err(pr); end
    checks++;
    if (err_count !== 8'hff || err_pulse !== 1'b1 || err_sticky !== 1'b1) begin
      fails++;
      $display("FAIL saturate got cnt=%0d pulse=%b sticky=%b want 255 1 1", err_count, err_pulse, err_sticky);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pr;
    do_clear();
    for (int i = 0; i < 3; i++) begin relock(); skip_err(pr); end
    relock();
    checks++;
    if (err_count !== 8'd3 || locked !== 1'b1) begin fails++; $display("FAIL pre_reset got cnt=%0d locked=%b want 3 1", err_count, locked); end
    rst = 1'b1; tick();
    checks++;
    if ({locked, wrap_pulse, err_pulse, err_sticky, log_valid} !== 5'd0 || err_count !== 8'd0 || wrap_count !== 8'd0 || exp_value !== 4'd0 || bad_value !== 4'd0 || log_data !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset got locked=%b cnt=%0d wraps=%0d exp=%0d bad=%0d want all 0", locked, err_count, wrap_count, exp_value, bad_value);
    end
    rst = 1'b0; en = 1'b0; tick();
    checks++;
    if (locked !== 1'b0) begin fails++; $display("FAIL disabled_locked got %b want 0", locked); end
  endtask

  initial begin
    test_reset();
    test_lock_and_wrap();
    test_skip();
    test_stall();
    test_clear_skip();
    test_log();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
